// File: rtl/ibis_phase_divider.sv
// Cascaded down-counting phase accumulator with ripple borrow between digits and a
// double-buffered, handshaked period register that takes effect only at reload points.
module ibis_phase_divider #(
  parameter int DIGIT_WIDTH = 4,
  parameter int NUM_DIGITS  = 4,
  localparam int W = DIGIT_WIDTH * NUM_DIGITS
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic                  mode_oneshot,
  input  logic                  phase_reset,
  input  logic                  period_valid,
  output logic                  period_ready,
  input  logic [W-1:0]          period_data,
  output logic [W-1:0]          phase,
  output logic [NUM_DIGITS-1:0] digit_zero,
  output logic                  phase_is_zero,
  output logic                  tick,
  output logic                  running
);

  localparam logic [DIGIT_WIDTH-1:0] DIG_ONE = 1;

  logic [W-1:0] phase_q, phase_d;
  logic [W-1:0] active_q, active_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic         pending_q, pending_d;
  logic         running_q, running_d;
  logic         tick_q, tick_d;

  logic [W-1:0]           dec_phase;
  logic [DIGIT_WIDTH-1:0] dig;
  logic                   borrow;
  logic                   accept, terminal, reload_evt, count_evt;
  logic [W-1:0]           reload_val;

  // Digit k borrows only when every lower digit is zero, which equals phase-1 overall.
  always_comb begin
    dec_phase  = phase_q;
    digit_zero = '0;
    dig        = '0;
    borrow     = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      dig           = phase_q[k*DIGIT_WIDTH +: DIGIT_WIDTH];
      digit_zero[k] = (dig == '0);
      if (borrow) dec_phase[k*DIGIT_WIDTH +: DIGIT_WIDTH] = dig - DIG_ONE;
      borrow = borrow & digit_zero[k];
    end
  end

  assign phase_is_zero = (phase_q == '0);
  assign period_ready  = aresetn & ~pending_q;
  assign phase         = phase_q;
  assign tick          = tick_q;
  assign running       = running_q;

  assign accept     = period_valid & period_ready;
  assign terminal   = enable & running_q & phase_is_zero;
  assign reload_evt = phase_reset | (terminal & ~mode_oneshot);
  assign count_evt  = enable & running_q & ~phase_is_zero;
  // A period arriving on the reload cycle bypasses the shadow register.
  assign reload_val = accept ? period_data : (pending_q ? shadow_q : active_q);

  always_comb begin
    phase_d   = phase_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    running_d = running_q;
    tick_d    = 1'b0;
    if (reload_evt) begin
      active_d  = reload_val;
      phase_d   = reload_val;
      pending_d = 1'b0;
    end else if (accept) begin
      shadow_d  = period_data;
      pending_d = 1'b1;
    end
    if (phase_reset) begin
      running_d = 1'b1;
    end else if (terminal) begin
      tick_d = 1'b1;
      if (mode_oneshot) running_d = 1'b0;
    end else if (count_evt) begin
      phase_d = dec_phase;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      phase_q   <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      running_q <= running_d;
      tick_q    <= tick_d;
    end
  end

endmodule
